// File: rtl/neuron_mac.sv
// neuron_mac: one neuron - serial multiply-accumulate, bias add, fixed-point rescale and saturation
//
// Ports:
//   clk       in   single clock, all state on posedge
//   rst       in   asynchronous active-low reset
//   in_valid  in   in_data valid this cycle
//   in_data   in   signed input activation (dataWidth, fracBits fractional)
//   in_ready  out  block can accept in_data (ACC state, no last input pending)
//   ren       out  weight-memory read enable (= accepted input)
//   radd      out  weight-memory read address (= weight counter)
//   wout      in   weight-memory read data, valid one cycle after ren
//   bias      in   signed neuron bias, held stable by the system
//   out_valid out  one-cycle pulse when out_data carries a new result
//   out_data  out  signed neuron result, held until the next result
//
// Build option: define RELU_EN to clamp negative results to zero (ReLU);
// otherwise the saturated result is passed through (linear activation).
module neuron_mac #(
    parameter int numWeight    = 3,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [dataWidth-1:0]    in_data,
    output logic                    in_ready,
    output logic                    ren,
    output logic [addressWidth-1:0] radd,
    input  logic [dataWidth-1:0]    wout,
    input  logic [dataWidth-1:0]    bias,
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out_data
);
    localparam int AW = 2 * dataWidth;
    localparam logic [addressWidth-1:0] LAST = addressWidth'(numWeight - 1);

    typedef enum logic [1:0] {ACC, BIAS, OUT} state_t;

    state_t                  state_q, state_d;
    logic [addressWidth-1:0] cnt_q, cnt_d;
    logic [dataWidth-1:0]    dat_q, dat_d;
    logic                    vld_q, vld_d;
    logic                    lst_q, lst_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic [dataWidth-1:0]    out_q, out_d;
    logic                    accept;
    logic signed [AW-1:0]    prod, biased, shifted;
    logic [dataWidth-1:0]    res, act;

    // Signed add clamped to the AW-bit range: overflow shows as the two top
    // bits of the one-bit-wider sum disagreeing.
    function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                     input logic signed [AW-1:0] b);
        logic signed [AW:0] s;
        s = {a[AW-1], a} + {b[AW-1], b};
        return (s[AW] != s[AW-1]) ? {s[AW], {(AW-1){~s[AW]}}} : s[AW-1:0];
    endfunction

    // Once the last input is in flight, stop accepting so the next neuron's
    // first input cannot land in the pipeline while the bias step runs.
    assign in_ready  = (state_q == ACC) && !lst_q;
    assign accept    = in_valid && in_ready;
    assign ren       = accept;
    assign radd      = cnt_q;
    assign out_valid = (state_q == OUT);
    assign out_data  = out_q;

    always_comb begin
        // Full product of two dataWidth words always fits in AW bits.
        prod    = AW'($signed(dat_q)) * AW'($signed(wout));
        biased  = sat_add(acc_q, AW'($signed(bias)) <<< fracBits);
        shifted = biased >>> fracBits;
        // In range iff every bit above the output sign bit matches it.
        res     = (&shifted[AW-1:dataWidth-1] || ~|shifted[AW-1:dataWidth-1])
                  ? shifted[dataWidth-1:0]
                  : {shifted[AW-1], {(dataWidth-1){~shifted[AW-1]}}};
`ifdef RELU_EN
        act     = res[dataWidth-1] ? '0 : res;
`else
        act     = res;
`endif
        cnt_d   = accept ? ((cnt_q == LAST) ? '0 : cnt_q + 1'b1) : cnt_q;
        dat_d   = accept ? in_data : dat_q;
        vld_d   = accept;
        lst_d   = accept && (cnt_q == LAST);
        acc_d   = (state_q == OUT) ? '0 : vld_q ? sat_add(acc_q, prod) : acc_q;
        out_d   = (state_q == BIAS) ? act : out_q;
        state_d = (state_q == ACC)  ? ((vld_q && lst_q) ? BIAS : ACC)
                : (state_q == BIAS) ? OUT
                : ACC;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ACC;
            cnt_q   <= '0;
            dat_q   <= '0;
            vld_q   <= 1'b0;
            lst_q   <= 1'b0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            lst_q   <= lst_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end
endmodule
